// File: rtl/mod3_residue_tx.sv
// Purpose : serial mod-3 link transmitter; shifts a W-bit word MSB-first, then a 2-bit check
//           field that makes the whole (W+2)-bit frame divisible by 3.
// Latency : first serial bit appears 1 clock after accept; a frame is W+2 contiguous bits.
// Backpr. : in_ready only in IDLE or on the last check bit (allows back-to-back frames);
//           in_valid while in_ready=0 is ignored and the word is not taken.
// Ports   : clk, rst (sync, active-high) | in_valid/in_data/in_ready word handshake |
//           ser_out/ser_valid serial bit, frame_last on final check bit, busy = frame mid-way.
module mod3_residue_tx #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         ser_out,
   output logic         ser_valid,
   output logic         frame_last,
   output logic         busy
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, CHK1, CHK0} state_t;

   state_t          state;
   logic [W-1:0]    sr;       // sr[W-1] is the bit currently on ser_out while in SHIFT
   logic [CW-1:0]   cnt;      // data bits remaining after the current one
   logic [1:0]      r;        // residue of the data bits already sent, mod 3

   logic            accept;
   logic [W-1:0]    sr_shl;
   logic [1:0]      r_next;
   logic [1:0]      chk_next; // check field from the residue including the current bit
   logic [1:0]      chk_cur;  // check field from the final registered residue

   // Check field c = (3 - r) mod 3
   function automatic logic [1:0] check_of(input logic [1:0] res);
      case (res)
         2'd1:    check_of = 2'b10;
         2'd2:    check_of = 2'b01;
         default: check_of = 2'b00;
      endcase
   endfunction

   always_comb begin
      in_ready = (state == IDLE) || (state == CHK0);
      accept   = in_valid && in_ready;
      sr_shl   = sr << 1;
      // (2*r + bit) mod 3 as a lookup, so r never reaches 3
      case ({r, sr[W-1]})
         3'b000:  r_next = 2'd0;
         3'b001:  r_next = 2'd1;
         3'b010:  r_next = 2'd2;
         3'b011:  r_next = 2'd0;
         3'b100:  r_next = 2'd1;
         3'b101:  r_next = 2'd2;
         default: r_next = 2'd0;
      endcase
      chk_next = check_of(r_next);
      chk_cur  = check_of(r);
   end

   assign busy = ser_valid && !frame_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sr         <= '0;
         cnt        <= '0;
         r          <= 2'd0;
         ser_out    <= 1'b0;
         ser_valid  <= 1'b0;
         frame_last <= 1'b0;
      end else begin
         case (state)
            // IDLE and CHK0 share the accept path; CHK0 reload gives gap-free frames
            IDLE, CHK0: begin
               if (accept) begin
                  state      <= SHIFT;
                  sr         <= in_data;
                  r          <= 2'd0;
                  cnt        <= CW'(W - 1);
                  ser_out    <= in_data[W-1];
                  ser_valid  <= 1'b1;
                  frame_last <= 1'b0;
               end else begin
                  state      <= IDLE;
                  ser_out    <= 1'b0;
                  ser_valid  <= 1'b0;
                  frame_last <= 1'b0;
               end
            end
            SHIFT: begin
               r <= r_next;
               if (cnt == '0) begin
                  state   <= CHK1;
                  ser_out <= chk_next[1];
               end else begin
                  sr      <= sr_shl;
                  ser_out <= sr_shl[W-1];
                  cnt     <= cnt - CW'(1);
               end
            end
            CHK1: begin
               state      <= CHK0;
               ser_out    <= chk_cur[0];
               frame_last <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               ser_out    <= 1'b0;
               ser_valid  <= 1'b0;
               frame_last <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod3_residue_tx.sv
module tb_mod3_residue_tx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         ser_out;
   logic         ser_valid;
   logic         frame_last;
   logic         busy;

   mod3_residue_tx #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .frame_last (frame_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected serial bit stream, built from whole frames
   bit eq_bit[$];
   bit eq_last[$];

   function automatic void push_frame(input logic [W-1:0] d);
      logic [W+1:0] fr;
      int rr;
      rr = int'(d) % 3;
      fr = {d, 2'((3 - rr) % 3)};
      for (int i = W + 1; i >= 0; i--) begin
         eq_bit.push_back(fr[i]);
         eq_last.push_back(i == 0);
      end
   endfunction

   // Observations of the DUT stream
   bit mon_en = 0;
   int cur_val = 0;
   int res3 = 0;
   int run = 0;
   int last_run = 0;
   int last_frame_val = -1;
   int frames_done = 0;

   always @(negedge clk) begin
      int qs;
      bit ev, eb, el;
      if (mon_en) begin
         qs = eq_bit.size();
         ev = 0; eb = 0; el = 0;
         if (qs > 0) begin
            ev = 1; eb = eq_bit[0]; el = eq_last[0];
         end
         chk("in_ready",   32'(in_ready),   32'((qs == 0) || (qs == 1)));
         chk("ser_valid",  32'(ser_valid),  32'(ev));
         chk("ser_out",    32'(ser_out),    32'(eb));
         chk("frame_last", 32'(frame_last), 32'(el));
         chk("busy",       32'(busy),       32'(ev && !el));
         if (qs > 0) begin
            void'(eq_bit.pop_front());
            void'(eq_last.pop_front());
         end
         // independent divisibility checker on the observed stream
         if (ser_valid === 1'b1) begin
            cur_val = (cur_val << 1) | int'(ser_out);
            res3 = (res3 * 2 + int'(ser_out)) % 3;
            run++;
            if (frame_last === 1'b1) begin
               chk("div3", 32'(res3), 32'd0);
               last_frame_val = cur_val;
               frames_done++;
               cur_val = 0;
               res3 = 0;
            end
         end else begin
            if (run > 0) last_run = run;
            run = 0;
         end
         if (rst) begin
            eq_bit.delete();
            eq_last.delete();
            cur_val = 0;
            res3 = 0;
         end else if (in_valid && in_ready) begin
            push_frame(in_data);
         end
      end
   end

   task automatic send(input logic [W-1:0] d);
      bit acc;
      acc = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            break;
         end
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (eq_bit.size() == 0) begin
            done = 1;
            break;
         end
      end
      if (!done) chk("idle_timeout", 32'd0, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [W-1:0] t3_dat [3];
   int           t3_exp [3];
   int           fd0;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1;

      // 1: idle after reset
      @(negedge clk);
      chk("rst_in_ready",   32'(in_ready),   32'd1);
      chk("rst_ser_valid",  32'(ser_valid),  32'd0);
      chk("rst_ser_out",    32'(ser_out),    32'd0);
      chk("rst_frame_last", 32'(frame_last), 32'd0);
      @(posedge clk);
      #1;

      // 2: 8'h05 -> 0000_0101 then 01, value 21, 10 bits
      send(8'h05);
      wait_idle();
      chk("frame_05", 32'(last_frame_val), 32'd21);
      chk("len_05",   32'(last_run),       32'd10);

      // 3: check fields 00, 10, 00
      t3_dat[0] = 8'h06; t3_exp[0] = 24;
      t3_dat[1] = 8'h07; t3_exp[1] = 30;
      t3_dat[2] = 8'hFF; t3_exp[2] = 1020;
      for (int i = 0; i < 3; i++) begin
         send(t3_dat[i]);
         wait_idle();
         chk("frame_t3", 32'(last_frame_val), 32'(t3_exp[i]));
      end

      // 4: back-to-back frames, 20 contiguous valid cycles
      send(8'hAA);
      send(8'h55);
      wait_idle();
      chk("b2b_run",  32'(last_run),       32'd20);
      chk("b2b_last", 32'(last_frame_val), 32'(8'h55 * 4 + 2));

      // 5: reset on 4th data bit with in_valid high
      fd0      = frames_done;
      in_valid = 1'b1;
      in_data  = 8'hC3;
      @(negedge clk);
      chk("t5_ready", 32'(in_ready), 32'd1);
      @(posedge clk);              // accept
      repeat (3) @(posedge clk);   // 4th data bit now on ser_out
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_ser_valid",  32'(ser_valid),  32'd0);
      chk("t5_frame_last", 32'(frame_last), 32'd0);
      chk("t5_in_ready",   32'(in_ready),   32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_frame", 32'(frames_done - fd0), 32'd0);

      // 6: 1000 random words with random gaps
      fd0 = frames_done;
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         send(W'($urandom));
      end
      wait_idle();
      chk("rand_frames", 32'(frames_done - fd0), 32'd1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
